rotate_issue_ctrl: RTL and testbench

Request-side controller for the 16-bit registered rotate-left datapath. It accepts rotate requests (word + 4-bit amount) over a valid/ready handshake and buffers them in an input FIFO. It launches at most one request per cycle into the rotator, tracks in-flight requests through the rotator's fixed latency, and captures results into an output FIFO drained over a second valid/ready handshake. Issue is credit-gated, so a result always has a guaranteed output slot; the rotator itself never stalls.

---
 rtl/rotate_issue_ctrl.sv | 138 +++++++++++++
 tb/tb_rotate_issue_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rotate_issue_ctrl : credit-gated issue/capture around a rotator    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rotate_issue_ctrl #(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 8,
  parameter int LAT       = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_data,
  input  logic [3:0]  req_amt,
  output logic [15:0] rot_in,
  output logic [3:0]  rot_amt,
  input  logic [15:0] rot_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [3:0]  res_amt,
  output logic        idle
);

  localparam int IPW  = (IN_DEPTH  > 1) ? $clog2(IN_DEPTH)  : 1;
  localparam int OPW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int ICW  = $clog2(IN_DEPTH + 1);
  localparam int OCW  = $clog2(OUT_DEPTH + 1);
  localparam int FCW  = $clog2(LAT + 1);
  localparam int SUMW = ((OCW > FCW) ? OCW : FCW) + 1;

  localparam logic [IPW-1:0]  C_IN_LAST  = IPW'(IN_DEPTH - 1);
  localparam logic [OPW-1:0]  C_OUT_LAST = OPW'(OUT_DEPTH - 1);
  localparam logic [ICW-1:0]  C_IN_FULL  = ICW'(IN_DEPTH);
  localparam logic [SUMW-1:0] C_CREDIT   = SUMW'(OUT_DEPTH);

  // FIFO entries are packed as {word, amount}
  logic [19:0]     r_in_mem  [IN_DEPTH];
  logic [19:0]     r_out_mem [OUT_DEPTH];
  logic [IPW-1:0]  r_in_wr, r_in_rd;
  logic [ICW-1:0]  r_in_count;
  logic [OPW-1:0]  r_out_wr, r_out_rd;
  logic [OCW-1:0]  r_out_count;
  logic [FCW-1:0]  r_inflight;
  logic [LAT-1:0]  r_pipe_vld;
  logic [3:0]      r_pipe_amt [LAT];

  logic            w_in_push, w_issue, w_out_push, w_out_pop;
  logic [19:0]     w_in_head, w_out_head;
  logic [SUMW-1:0] w_committed;

  function automatic logic [IPW-1:0] in_next(input logic [IPW-1:0] p);
    return (p == C_IN_LAST) ? '0 : p + IPW'(1);
  endfunction

  function automatic logic [OPW-1:0] out_next(input logic [OPW-1:0] p);
    return (p == C_OUT_LAST) ? '0 : p + OPW'(1);
  endfunction

  assign w_in_head   = r_in_mem[r_in_rd];
  assign w_out_head  = r_out_mem[r_out_rd];
  // Every result already promised an output slot counts against the credit
  assign w_committed = SUMW'(r_out_count) + SUMW'(r_inflight);
  assign w_in_push   = req_valid & req_ready;
  assign w_issue     = (r_in_count != '0) & (w_committed < C_CREDIT);
  assign w_out_push  = r_pipe_vld[LAT-1];
  assign w_out_pop   = res_valid & res_ready;

  always_ff @(posedge clk) begin
    if (w_in_push)  r_in_mem[r_in_wr]   <= {req_data, req_amt};
    if (w_out_push) r_out_mem[r_out_wr] <= {rot_out, r_pipe_amt[LAT-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_wr    <= '0;
      r_in_rd    <= '0;
      r_in_count <= '0;
    end else begin
      if (w_in_push) r_in_wr <= in_next(r_in_wr);
      if (w_issue)   r_in_rd <= in_next(r_in_rd);
      case ({w_in_push, w_issue})
        2'b10:   r_in_count <= r_in_count + ICW'(1);
        2'b01:   r_in_count <= r_in_count - ICW'(1);
        default: r_in_count <= r_in_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_in     <= '0;
      rot_amt    <= '0;
      r_pipe_vld <= '0;
      r_inflight <= '0;
      for (int i = 0; i < LAT; i++) r_pipe_amt[i] <= '0;
    end else begin
      if (w_issue) begin
        rot_in  <= w_in_head[19:4];
        rot_amt <= w_in_head[3:0];
      end
      r_pipe_vld    <= LAT'({r_pipe_vld, w_issue});
      r_pipe_amt[0] <= w_in_head[3:0];
      for (int i = 1; i < LAT; i++) r_pipe_amt[i] <= r_pipe_amt[i-1];
      case ({w_issue, w_out_push})
        2'b10:   r_inflight <= r_inflight + FCW'(1);
        2'b01:   r_inflight <= r_inflight - FCW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_wr    <= '0;
      r_out_rd    <= '0;
      r_out_count <= '0;
    end else begin
      if (w_out_push) r_out_wr <= out_next(r_out_wr);
      if (w_out_pop)  r_out_rd <= out_next(r_out_rd);
      case ({w_out_push, w_out_pop})
        2'b10:   r_out_count <= r_out_count + OCW'(1);
        2'b01:   r_out_count <= r_out_count - OCW'(1);
        default: r_out_count <= r_out_count;
      endcase
    end
  end

  assign req_ready = (r_in_count < C_IN_FULL);
  assign res_valid = (r_out_count != '0);
  assign res_data  = res_valid ? w_out_head[19:4] : '0;
  assign res_amt   = res_valid ? w_out_head[3:0]  : '0;
  assign idle      = (r_in_count == '0) & (r_out_count == '0) & (r_inflight == '0);

endmodule
`default_nettype wire

// File: tb/tb_rotate_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rotate_issue_ctrl : scoreboard bench with a modelled rotator    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_rotate_issue_ctrl;
  localparam int IN_DEPTH  = 4;
  localparam int OUT_DEPTH = 8;
  localparam int LAT       = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [15:0] req_data = '0;
  logic [3:0]  req_amt = '0;
  logic [15:0] rot_in, rot_out;
  logic [3:0]  rot_amt;
  logic        res_valid, res_ready = 1'b0;
  logic [15:0] res_data;
  logic [3:0]  res_amt;
  logic        idle;

  int n_pass = 0;
  int n_total = 0;
  logic [19:0] src_q[$];
  logic [19:0] exp_q[$];
  logic [15:0] rot_s1, rot_s2;

  rotate_issue_ctrl #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_amt(req_amt),
    .rot_in(rot_in), .rot_amt(rot_amt), .rot_out(rot_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_amt(res_amt),
    .idle(idle)
  );

  function automatic logic [15:0] rotl(input logic [15:0] d, input logic [3:0] a);
    logic [31:0] t;
    t = {d, d} << a;
    return t[31:16];
  endfunction

  always #5 clk = ~clk;

  // Unreset rotator: LAT-1 register stages between rot_in and rot_out
  always @(posedge clk) begin
    rot_s1 <= rotl(rot_in, rot_amt);
    rot_s2 <= rot_s1;
  end
  assign rot_out = rot_s2;

  always @(negedge clk) begin
    if (rst_n && dut.w_out_push && !dut.w_out_pop && dut.r_out_count == OUT_DEPTH) begin
      $display("FAIL out_overflow: push into full output FIFO at %0t", $time);
      n_total++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = 1'b0;
    res_ready = 1'b0;
    src_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive(input int pv, input int pr);
    req_valid = (src_q.size() != 0) && ($urandom_range(99) < pv);
    {req_data, req_amt} = (src_q.size() != 0) ? src_q[0] : 20'h0;
    res_ready = ($urandom_range(99) < pr);
  endtask

  // One clock: sample at negedge, update the reference queues, end at posedge+1
  task automatic step(output bit pop, output bit under, output logic [19:0] got,
                      output logic [19:0] want);
    @(negedge clk);
    pop   = res_valid && res_ready;
    got   = {res_data, res_amt};
    under = 1'b0;
    want  = '0;
    if (pop) begin
      if (exp_q.size() == 0) under = 1'b1;
      else want = exp_q.pop_front();
    end
    if (req_valid && req_ready) begin
      exp_q.push_back({rotl(src_q[0][19:4], src_q[0][3:0]), src_q[0][3:0]});
      void'(src_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) src_q.push_back(20'($urandom));
  endtask

  task automatic test_reset;
    do_reset();
    n_total++;
    if ({req_ready, res_valid, idle} !== 3'b101)
      $display("FAIL reset_flags: ready/valid/idle got %b want 101", {req_ready, res_valid, idle});
    else n_pass++;
    n_total++;
    if ({res_data, res_amt, rot_in, rot_amt} !== 40'h0)
      $display("FAIL reset_data: got %h want 0", {res_data, res_amt, rot_in, rot_amt});
    else n_pass++;
  endtask

  task automatic test_single;
    bit pop, under;
    logic [19:0] got, want;
    int first;
    do_reset();
    src_q.push_back({16'h1234, 4'd4});
    drive(100, 0);
    step(pop, under, got, want);
    n_total++;
    if (src_q.size() != 0) $display("FAIL single_accept: pending %0d want 0", src_q.size());
    else n_pass++;
    req_valid = 1'b0;
    first = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (res_valid && first < 0) begin
        first = i;
        n_total++;
        if ({res_data, res_amt} !== {16'h2341, 4'd4})
          $display("FAIL single_data: got %h want 23414", {res_data, res_amt});
        else n_pass++;
      end
      @(posedge clk);
      #1;
      if (first >= 0) break;
    end
    n_total++;
    if (first != 5) $display("FAIL single_latency: first valid cycle %0d want 5", first);
    else n_pass++;
    res_ready = 1'b1;
    step(pop, under, got, want);
    res_ready = 1'b0;
    n_total++;
    if (!pop || under || got !== want)
      $display("FAIL single_pop: pop %0b got %h want %h", pop, got, want);
    else n_pass++;
    n_total++;
    if (idle !== 1'b1) $display("FAIL single_idle: got %b want 1", idle);
    else n_pass++;
  endtask

  task automatic test_amount_edges;
    bit pop, under;
    logic [19:0] got, want;
    logic [19:0] ref_res [3];
    int pops;
    ref_res[0] = {16'hA5C3, 4'd0};
    ref_res[1] = {16'h0003, 4'd1};
    ref_res[2] = {16'h8000, 4'd15};
    do_reset();
    src_q.push_back({16'hA5C3, 4'd0});
    src_q.push_back({16'h8001, 4'd1});
    src_q.push_back({16'h0001, 4'd15});
    pops = 0;
    for (int c = 0; c < 40 && pops < 3; c++) begin
      drive(100, 100);
      step(pop, under, got, want);
      if (pop) begin
        n_total++;
        if (under || got !== ref_res[pops])
          $display("FAIL amt_edge_%0d: got %h want %h", pops, got, ref_res[pops]);
        else n_pass++;
        pops++;
      end
    end
    n_total++;
    if (pops != 3) $display("FAIL amt_edge_count: got %0d want 3", pops);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    bit pop, under, started;
    logic [19:0] got, want;
    int pops, bubbles, bad;
    do_reset();
    push_random(20);
    pops = 0; bubbles = 0; bad = 0; started = 1'b0;
    for (int c = 0; c < 80 && pops < 20; c++) begin
      drive(100, 100);
      step(pop, under, got, want);
      if (pop) begin
        started = 1'b1;
        pops++;
        if (under || got !== want) begin
          bad++;
          $display("FAIL stream_data: got %h want %h", got, want);
        end
      end else if (started) bubbles++;
    end
    n_total++;
    if (bad != 0) $display("FAIL stream_mismatches: got %0d want 0", bad);
    else n_pass++;
    n_total++;
    if (pops != 20) $display("FAIL stream_count: got %0d want 20", pops);
    else n_pass++;
    n_total++;
    if (bubbles != 0) $display("FAIL stream_bubbles: got %0d want 0", bubbles);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    bit pop, under;
    logic [19:0] got, want;
    int pops, bad;
    do_reset();
    push_random(14);
    for (int c = 0; c < 30; c++) begin
      drive(100, 0);
      step(pop, under, got, want);
    end
    n_total++;
    if (14 - src_q.size() != IN_DEPTH + OUT_DEPTH)
      $display("FAIL bp_accepted: got %0d want %0d", 14 - src_q.size(), IN_DEPTH + OUT_DEPTH);
    else n_pass++;
    n_total++;
    if (req_ready !== 1'b0) $display("FAIL bp_ready: got %b want 0", req_ready);
    else n_pass++;
    src_q.delete();
    pops = 0; bad = 0;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      drive(0, 100);
      step(pop, under, got, want);
      if (pop) begin
        pops++;
        if (under || got !== want) begin
          bad++;
          $display("FAIL bp_drain_data: got %h want %h", got, want);
        end
      end
    end
    n_total++;
    if (pops != 12 || bad != 0) $display("FAIL bp_drain: pops %0d bad %0d want 12/0", pops, bad);
    else n_pass++;
    n_total++;
    if (idle !== 1'b1) $display("FAIL bp_idle: got %b want 1", idle);
    else n_pass++;
  endtask

  task automatic test_random;
    bit pop, under;
    logic [19:0] got, want;
    int pv[3], pr[3];
    int bad;
    pv[0] = 70; pr[0] = 50;
    pv[1] = 90; pr[1] = 15;
    pv[2] = 30; pr[2] = 90;
    do_reset();
    for (int ph = 0; ph < 3; ph++) begin
      push_random(80);
      bad = 0;
      for (int c = 0; c < 3000 && (src_q.size() != 0 || exp_q.size() != 0); c++) begin
        drive(pv[ph], pr[ph]);
        step(pop, under, got, want);
        if (pop && (under || got !== want)) begin
          bad++;
          $display("FAIL rand_data: phase %0d under %0b got %h want %h", ph, under, got, want);
        end
      end
      n_total++;
      if (bad != 0) $display("FAIL rand_mismatches: phase %0d got %0d want 0", ph, bad);
      else n_pass++;
      n_total++;
      if (src_q.size() != 0 || exp_q.size() != 0)
        $display("FAIL rand_drain: phase %0d left %0d/%0d want 0/0", ph, src_q.size(), exp_q.size());
      else n_pass++;
      req_valid = 1'b0;
      n_total++;
      if (idle !== 1'b1) $display("FAIL rand_idle: phase %0d got %b want 1", ph, idle);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    bit pop, under;
    logic [19:0] got, want;
    int pops;
    do_reset();
    push_random(8);
    for (int c = 0; c < 6; c++) begin
      drive(100, 0);
      step(pop, under, got, want);
    end
    n_total++;
    if (res_valid !== 1'b1) $display("FAIL midrst_pre: res_valid %b want 1", res_valid);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({req_ready, res_valid, idle} !== 3'b101)
      $display("FAIL midrst_flags: got %b want 101", {req_ready, res_valid, idle});
    else n_pass++;
    n_total++;
    if ({res_data, res_amt, rot_in, rot_amt} !== 40'h0)
      $display("FAIL midrst_data: got %h want 0", {res_data, res_amt, rot_in, rot_amt});
    else n_pass++;
    req_valid = 1'b0;
    src_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pops = 0;
    for (int c = 0; c < 10; c++) begin
      drive(0, 100);
      step(pop, under, got, want);
      if (pop) pops++;
    end
    n_total++;
    if (pops != 0) $display("FAIL midrst_stale: got %0d results want 0", pops);
    else n_pass++;
    n_total++;
    if (idle !== 1'b1) $display("FAIL midrst_idle: got %b want 1", idle);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_amount_edges();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
